cpu_run_ctrl: RTL

//  Execution sequencer for the multi-cycle CPU: generates the one-cycle clock enable (cpu_en)

---
 rtl/cpu_dbg_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/cpu_run_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU debug/run-control blocks: CPU control-state codes,
// sequencer run states, front-panel mode codes and the default HALT opcode.
package cpu_dbg_pkg;

  localparam logic [2:0] CPU_IF    = 3'b000;
  localparam logic [2:0] CPU_ID    = 3'b001;
  localparam logic [2:0] CPU_EXE_R = 3'b110;
  localparam logic [2:0] CPU_EXE_I = 3'b101;
  localparam logic [2:0] CPU_EXE_M = 3'b010;
  localparam logic [2:0] CPU_WB_R  = 3'b111;
  localparam logic [2:0] CPU_WB_M  = 3'b100;
  localparam logic [2:0] CPU_MEM   = 3'b011;

  localparam logic [5:0] HALT_OP_DEF = 6'b111111;

  typedef enum logic [2:0] {
    RS_IDLE     = 3'd0,
    RS_RUN      = 3'd1,
    RS_STEP_CYC = 3'd2,
    RS_STEP_INS = 3'd3,
    RS_HALT     = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    MODE_HALT     = 2'b00,
    MODE_RUN      = 2'b01,
    MODE_STEP_CYC = 2'b10,
    MODE_STEP_INS = 2'b11
  } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a single
// one-cycle pulse on each accepted press. Release is debounced but produces no pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse
);

  localparam int unsigned CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;

  // NOTE: every output of this block gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    sync_d   = {sync_q[0], btn_in};
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulse_d = stable_d & ~stable_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, which is what makes the synchroniser a chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer for the multi-cycle CPU: produces cpu_en for halt / run /
// step-cycle / step-instruction, with breakpoint, HALT opcode, step watchdog and counters.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEB_CYC = 100000,
  parameter int unsigned WDOG    = 8,
  parameter logic [5:0]  HALT_OP = HALT_OP_DEF
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic [2:0]       state_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  output logic             cpu_en,
  output logic             halted,
  output logic             wdog_err,
  output logic [2:0]       run_state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WW = $clog2(WDOG + 1);

  run_state_e       state_q, state_d;
  logic             en_d_q;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic             wdog_err_q, wdog_err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  logic step_pulse;
  logic retire, haltop, bp_hit, wdog_hit;
  logic unused_instr_bits;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_step_deb (
    .clk    (CLK),
    .rst_n  (Rst),
    .btn_in (step_btn),
    .pulse  (step_pulse)
  );

  // The CPU reacts to cpu_en one edge later, so en_d_q qualifies what state_in shows now.
  assign retire   = en_d_q & (state_in == CPU_IF);
  assign haltop   = en_d_q & (state_in == CPU_ID) & (instr_in[31:26] == HALT_OP);
  assign bp_hit   = retire & bp_en & (pc_in == bp_addr);
  assign wdog_hit = (wdog_q == WW'(WDOG)) & ~retire;

  assign unused_instr_bits = ^instr_in[25:0];

  always_comb begin
    state_d    = state_q;
    cpu_en     = 1'b0;
    wdog_d     = wdog_q;
    wdog_err_d = wdog_err_q;
    unique case (state_q)
      RS_IDLE: begin
        if (haltop) begin
          state_d = RS_HALT;
        end else if (mode == MODE_RUN) begin
          state_d = RS_RUN;
        end else if (step_pulse && (mode == MODE_STEP_CYC)) begin
          state_d = RS_STEP_CYC;
        end else if (step_pulse && (mode == MODE_STEP_INS)) begin
          state_d = RS_STEP_INS;
          wdog_d  = '0;
        end
      end
      RS_RUN: begin
        cpu_en = (mode == MODE_RUN) & ~haltop & ~bp_hit;
        if (haltop || bp_hit) begin
          state_d = RS_HALT;
        end else if (mode != MODE_RUN) begin
          state_d = RS_IDLE;
        end
      end
      RS_STEP_CYC: begin
        cpu_en  = 1'b1;
        state_d = RS_IDLE;
      end
      RS_STEP_INS: begin
        cpu_en = ~haltop & ~wdog_hit & ~retire & (mode != MODE_HALT);
        wdog_d = wdog_q + WW'(cpu_en);
        if (haltop) begin
          state_d = RS_HALT;
        end else if (wdog_hit) begin
          state_d    = RS_HALT;
          wdog_err_d = 1'b1;
        end else if (retire || (mode == MODE_HALT)) begin
          state_d = RS_IDLE;
        end
      end
      RS_HALT: begin
        if (mode == MODE_HALT) begin
          state_d = RS_IDLE;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  // Both counters stick at all-ones so the display never shows a misleading wrap.
  always_comb begin
    cyc_d   = cyc_q;
    instr_d = instr_q;
    if (cpu_en && (cyc_q != '1)) begin
      cyc_d = cyc_q + CNT_W'(1);
    end
    if (retire && (instr_q != '1)) begin
      instr_d = instr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state_q    <= RS_IDLE;
      en_d_q     <= 1'b0;
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
      cyc_q      <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_d_q     <= cpu_en;
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
      cyc_q      <= cyc_d;
      instr_q    <= instr_d;
    end
  end

  assign halted    = (state_q == RS_HALT);
  assign wdog_err  = wdog_err_q;
  assign run_state = state_q;
  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;

endmodule
